// File: rtl/score_seg7_scanner.sv
// Score display scanner: shadows both players' BCD digits on a load handshake
// and time-multiplexes them onto a 4-digit active-low 7-segment display, with
// leading-zero blanking, an error dash for invalid BCD and a whole-display blink.
module score_seg7_scanner #(
   parameter int unsigned REFRESH_DIV = 100_000,
   parameter int unsigned BLINK_DIV   = 25_000_000,
   parameter bit          BLANK_LEAD  = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] l_dig0_i,
   input  logic [3:0] l_dig1_i,
   input  logic [3:0] r_dig0_i,
   input  logic [3:0] r_dig1_i,
   input  logic       load_req_i,
   output logic       load_ack_o,
   input  logic       blink_en_i,
   output logic [6:0] seg_o,
   output logic       dp_o,
   output logic [3:0] an_o
);

   localparam int unsigned RefW   = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam int unsigned BlinkW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

   // Shadow slots in scan order: {l_dig1, l_dig0, r_dig1, r_dig0}
   logic [3:0][3:0]  shadow_q, shadow_d;
   logic [1:0]       idx_q, idx_d;
   logic [RefW-1:0]  refresh_q, refresh_d;
   logic [BlinkW-1:0] blink_q, blink_d;
   logic             phase_q, phase_d;
   logic             load_ack_q;
   logic [6:0]       seg_q, seg_d;
   logic             dp_q, dp_d;
   logic [3:0]       an_q, an_d;
   logic [3:0]       digit;
   logic [6:0]       glyph;

   // Next-state: capture, refresh scan and blink phase
   always_comb begin
      shadow_d  = shadow_q;
      idx_d     = idx_q;
      refresh_d = refresh_q + RefW'(1);
      blink_d   = '0;
      phase_d   = 1'b1;
      if (load_req_i) begin
         shadow_d = {l_dig1_i, l_dig0_i, r_dig1_i, r_dig0_i};
      end
      if (refresh_q == RefW'(REFRESH_DIV - 1)) begin
         refresh_d = '0;
         idx_d     = idx_q + 2'd1;
      end
      if (blink_en_i) begin
         phase_d = phase_q;
         if (blink_q == BlinkW'(BLINK_DIV - 1)) begin
            phase_d = ~phase_q;
         end else begin
            blink_d = blink_q + BlinkW'(1);
         end
      end
   end

   // Output decode from the current slot; registered one cycle late
   always_comb begin
      digit = shadow_q[idx_q];
      unique case (digit)
         4'd0:    glyph = 7'h40;
         4'd1:    glyph = 7'h79;
         4'd2:    glyph = 7'h24;
         4'd3:    glyph = 7'h30;
         4'd4:    glyph = 7'h19;
         4'd5:    glyph = 7'h12;
         4'd6:    glyph = 7'h02;
         4'd7:    glyph = 7'h78;
         4'd8:    glyph = 7'h00;
         4'd9:    glyph = 7'h10;
         default: glyph = 7'h3F;
      endcase
      seg_d = glyph;
      // Odd slots hold tens digits
      if (BLANK_LEAD && idx_q[0] && (digit == 4'd0)) begin
         seg_d = 7'h7F;
      end
      dp_d = (idx_q != 2'd2);
      an_d = ~(4'b0001 << idx_q);
      // Dropping blink_en takes effect at once, ahead of phase_q catching up
      if (blink_en_i && !phase_q) begin
         an_d = 4'hF;
      end
   end

   // State and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shadow_q   <= '0;
         idx_q      <= '0;
         refresh_q  <= '0;
         blink_q    <= '0;
         phase_q    <= 1'b1;
         load_ack_q <= 1'b0;
         seg_q      <= 7'h7F;
         dp_q       <= 1'b1;
         an_q       <= 4'hF;
      end else begin
         shadow_q   <= shadow_d;
         idx_q      <= idx_d;
         refresh_q  <= refresh_d;
         blink_q    <= blink_d;
         phase_q    <= phase_d;
         load_ack_q <= load_req_i;
         seg_q      <= seg_d;
         dp_q       <= dp_d;
         an_q       <= an_d;
      end
   end

   assign load_ack_o = load_ack_q;
   assign seg_o      = seg_q;
   assign dp_o       = dp_q;
   assign an_o       = an_q;

endmodule

// File: tb/tb_score_seg7_scanner.sv
// Bench for score_seg7_scanner: directed steps followed by random traffic, each
// cycle compared against a cycle-count based reference of the display.
module tb_score_seg7_scanner;

   localparam int unsigned RefDiv   = 4;
   localparam int unsigned BlinkDiv = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] l_dig0, l_dig1, r_dig0, r_dig1;
   logic       load_req, blink_en;
   logic       load_ack, dp, load_ack0, dp0;
   logic [6:0] seg, seg0;
   logic [3:0] an, an0;

   score_seg7_scanner #(
      .REFRESH_DIV(RefDiv), .BLINK_DIV(BlinkDiv), .BLANK_LEAD(1'b1)
   ) dut (
      .clk(clk), .reset(reset),
      .l_dig0_i(l_dig0), .l_dig1_i(l_dig1), .r_dig0_i(r_dig0), .r_dig1_i(r_dig1),
      .load_req_i(load_req), .load_ack_o(load_ack), .blink_en_i(blink_en),
      .seg_o(seg), .dp_o(dp), .an_o(an)
   );

   score_seg7_scanner #(
      .REFRESH_DIV(RefDiv), .BLINK_DIV(BlinkDiv), .BLANK_LEAD(1'b0)
   ) dut0 (
      .clk(clk), .reset(reset),
      .l_dig0_i(l_dig0), .l_dig1_i(l_dig1), .r_dig0_i(r_dig0), .r_dig1_i(r_dig1),
      .load_req_i(load_req), .load_ack_o(load_ack0), .blink_en_i(blink_en),
      .seg_o(seg0), .dp_o(dp0), .an_o(an0)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference state: edges since reset, consecutive blink-enabled edges, shadows
   int         k;
   int         run;
   logic [3:0] sh [4];

   function automatic logic [6:0] glyph(input logic [3:0] v);
      case (v)
         4'd0: return 7'h40;
         4'd1: return 7'h79;
         4'd2: return 7'h24;
         4'd3: return 7'h30;
         4'd4: return 7'h19;
         4'd5: return 7'h12;
         4'd6: return 7'h02;
         4'd7: return 7'h78;
         4'd8: return 7'h00;
         4'd9: return 7'h10;
         default: return 7'h3F;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      k   = 0;
      run = 0;
      for (int i = 0; i < 4; i++) sh[i] = 4'd0;
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_an"}, {4'd0, an}, 8'h0F);
      chk({tag, "_seg"}, {1'b0, seg}, 8'h7F);
      chk({tag, "_dp"}, {7'd0, dp}, 8'h01);
      chk({tag, "_ack"}, {7'd0, load_ack}, 8'h00);
      chk({tag, "_seg0"}, {1'b0, seg0}, 8'h7F);
   endtask

   // One clock: predict from pre-edge inputs/state, advance model, compare
   task automatic step();
      int         slot;
      bit         on;
      logic [6:0] e_seg, e_seg0;
      logic [3:0] e_an;
      logic       e_dp, e_ack;
      slot   = (k / RefDiv) % 4;
      on     = ((run / BlinkDiv) % 2) == 0;
      e_seg0 = glyph(sh[slot]);
      e_seg  = ((slot == 1 || slot == 3) && sh[slot] == 4'd0) ? 7'h7F : e_seg0;
      e_an   = (blink_en && !on) ? 4'hF : ~(4'b0001 << slot);
      e_dp   = (slot != 2);
      e_ack  = load_req;
      @(posedge clk);
      if (load_req) begin
         sh[0] = r_dig0;
         sh[1] = r_dig1;
         sh[2] = l_dig0;
         sh[3] = l_dig1;
      end
      run = blink_en ? run + 1 : 0;
      k++;
      #1;
      chk("an", {4'd0, an}, {4'd0, e_an});
      chk("seg", {1'b0, seg}, {1'b0, e_seg});
      chk("dp", {7'd0, dp}, {7'd0, e_dp});
      chk("load_ack", {7'd0, load_ack}, {7'd0, e_ack});
      chk("seg_noblank", {1'b0, seg0}, {1'b0, e_seg0});
   endtask

   initial begin
      l_dig0 = 4'd0; l_dig1 = 4'd0; r_dig0 = 4'd0; r_dig1 = 4'd0;
      load_req = 1'b0; blink_en = 1'b0;
      model_reset();

      // Reset values, then first drive on the first edge after release
      repeat (2) @(posedge clk);
      #1;
      check_reset("reset");
      reset = 1'b0;
      step();
      chk("first_an", {4'd0, an}, 8'h0E);
      chk("first_seg", {1'b0, seg}, 8'h40);

      // Left 12, right 07: one-cycle load pulse then full scan
      l_dig1 = 4'd1; l_dig0 = 4'd2; r_dig1 = 4'd0; r_dig0 = 4'd7;
      load_req = 1'b1;
      step();
      load_req = 1'b0;
      repeat (20) step();

      // Digit changes without load_req must not reach the display
      l_dig1 = 4'd9; l_dig0 = 4'd8; r_dig1 = 4'd5; r_dig0 = 4'd3;
      repeat (8) step();

      // Invalid BCD dash and a zero tens digit on both blanking settings
      r_dig0 = 4'hA; r_dig1 = 4'd0;
      load_req = 1'b1;
      step();
      load_req = 1'b0;
      repeat (16) step();

      // Blink, dropped during the off phase, then re-enabled
      blink_en = 1'b1;
      repeat (12) step();
      blink_en = 1'b0;
      repeat (2) step();
      blink_en = 1'b1;
      repeat (25) step();

      // Async reset during slot 2 with blink on
      for (int i = 0; i < 16 && ((k / RefDiv) % 4) != 2; i++) step();
      chk("slot2_reached", 8'(((k / RefDiv) % 4)), 8'd2);
      reset = 1'b1;
      #1;
      check_reset("midscan_reset");
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_reset("held_reset");
      reset = 1'b0;
      repeat (6) step();

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         l_dig0   = 4'($urandom);
         l_dig1   = 4'($urandom_range(0, 11));
         r_dig0   = 4'($urandom);
         r_dig1   = 4'($urandom_range(0, 11));
         load_req = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 20) == 0) blink_en = ~blink_en;
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
